uart_cmd_master: RTL and testbench
==================================

# uart_cmd_master

On-FPGA initiator for the scene/camera command protocol carried over the 8N1 UART. It accepts one command at a time from a local controller (test sequencer, boot-time scene loader, or debug console bridge) and serialises it as `tag | len | payload | checksum`. It then waits for the single-byte response and, for the frame-number query, collects the 4-byte counter that follows. It sits between the controller and the UART TX/RX byte cores, on the opposite end of the link from the command processor.

## Interface
Parameters:
- `MAX_LEN`, default 38: maximum payload bytes; 38 covers the material command's 1 id byte plus 289 bits.
- `TIMEOUT_CYCLES`, default 1_000_000: response timeout in clk cycles.
- `MAX_RETRIES`, default 3: number of resends after a checksum NACK.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous reset, active low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block idle and able to accept a command.
- `cmd_tag` in 8: command tag.
- `cmd_len` in 8: payload length in bytes.
- `cmd_payload` in 8*MAX_LEN: payload; bit j is bit j of the receiver's buffer.
- `uart_tx_busy` in 1: TX core busy.
- `uart_tx_start` out 1: one-cycle start strobe.
- `uart_tx_byte` out 8: byte to transmit.
- `uart_rx_new_data` in 1: one-cycle strobe, received byte valid.
- `uart_rx_byte` in 8: received byte.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_status` out 3: 0 OK, 1 NACK, 2 UNKNOWN_TAG, 3 TIMEOUT, 4 BAD_LEN, 5 PROTO_ERR.
- `rsp_frame_num` out 32: frame counter. Valid with OK status for tag 0x05; holds its previous value otherwise.

## Operation
- Accept: a command is accepted on `cmd_valid & cmd_ready`. Tag, len and payload are latched in that cycle. `cmd_ready` drops the next cycle and rises again the cycle after `rsp_valid`.
- Length check: `cmd_len > MAX_LEN` sends nothing. The block returns BAD_LEN on the cycle after accept.
- States: IDLE → SEND_TAG → SEND_LEN → SEND_PAYLOAD (skipped when len = 0) → SEND_CSUM → WAIT_ACK → (RECV_FRAME) → IDLE.
- Wire encoding: payload byte k goes on the wire bit-reversed, so wire bit (7−i) = `cmd_payload[8k+i]`. Bytes are sent in order k = 0..len−1.
- Checksum: XOR of the tag, len and all payload wire bytes, in 8 bits.
- WAIT_ACK responses:
  - 0x00: tag ≠ 0x05 completes with OK; tag 0x05 goes to RECV_FRAME.
  - 0xFF: resend the whole frame from SEND_TAG while the retry count is below `MAX_RETRIES`; otherwise complete with NACK.
  - 0x01: complete with UNKNOWN_TAG.
  - Any other byte: complete with PROTO_ERR.
- RECV_FRAME: collects 4 raw bytes (not bit-reversed), LSB first, into `rsp_frame_num`, then completes with OK.
- Timeout: a counter is cleared on entering WAIT_ACK and on every RX byte while in WAIT_ACK or RECV_FRAME. When it reaches `TIMEOUT_CYCLES` the block completes with TIMEOUT. There is no retry on timeout.
- RX bytes arriving in any other state are discarded.
- Retry counter clears on each accepted command.

## Timing
- Reset (`rst_n` = 0 at a clk edge) forces: state IDLE, `cmd_ready` 0, `uart_tx_start` 0, `uart_tx_byte` 0x00, `rsp_valid` 0, `rsp_status` 0, `rsp_frame_num` 0, all counters 0. `cmd_ready` goes to 1 the first cycle after release.
- Reset mid-frame aborts at once. No further `uart_tx_start` is issued and no `rsp_valid` is produced for the aborted command.
- TX handshake: a start strobe is issued only in a cycle where `uart_tx_busy` = 0. After a strobe at cycle t, the next strobe is no earlier than t+2 and only once busy is sampled low at or after t+2.
- First strobe (tag) comes at accept+1 when TX is idle.
- `uart_tx_byte` holds its value from the strobe cycle until the next strobe.
- WAIT_ACK is entered the cycle after the checksum strobe.
- A response byte at cycle t gives `rsp_valid` at t+1; tag 0x05 gives `rsp_valid` at t+1 of the 4th frame byte.
- Timeout: `rsp_valid` fires exactly `TIMEOUT_CYCLES` cycles after the last counter clear.
- An RX strobe in the same cycle the timeout fires is ignored; the timeout wins.
- A resend's tag strobe follows the 0xFF byte by at least 1 cycle and obeys the TX handshake.

## Test plan
- Tag 0x08, len 1, payload 0x02 → wire bytes 08 01 40 49; reply 00 → `rsp_valid` with status 0 one cycle later.
- Same command, replies FF FF 00 (MAX_RETRIES=3) → frame sent 3 times, status OK. Replies FF ×4 → 4 transmissions, then status NACK.
- Tag 0x05, len 0 → wire 05 00 05; reply 00 2A 01 00 00 → status OK, `rsp_frame_num` = 0x0000012A.
- TIMEOUT_CYCLES=100, no reply → status TIMEOUT exactly 100 cycles after WAIT_ACK entry; reply 0x37 instead → PROTO_ERR.
- cmd_len = 39 with MAX_LEN = 38 → BAD_LEN at accept+1, no TX strobe. TX busy held high for 50 cycles → no strobe until busy drops.
- `rst_n` low during the 3rd payload byte of a 12-byte material command → no further strobes, no `rsp_valid`, `cmd_ready`=1 after release; next command runs normally.

Source files
------------

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: serialises tag|len|payload|csum over a UART byte core and collects the response
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_tag, cmd_len, cmd_payload latched on accept
//   uart_tx_busy/start/byte    TX byte core interface (start is a one-cycle strobe)
//   uart_rx_new_data/rx_byte   RX byte core interface (one-cycle strobe)
//   rsp_valid/status/frame_num one-cycle completion strobe, status code, frame counter for tag 0x05
module uart_cmd_master #(
  parameter int MAX_LEN        = 38,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [7:0]           cmd_tag,
  input  logic [7:0]           cmd_len,
  input  logic [8*MAX_LEN-1:0] cmd_payload,
  input  logic                 uart_tx_busy,
  output logic                 uart_tx_start,
  output logic [7:0]           uart_tx_byte,
  input  logic                 uart_rx_new_data,
  input  logic [7:0]           uart_rx_byte,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_status,
  output logic [31:0]          rsp_frame_num
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {
    IDLE, SEND_TAG, SEND_LEN, SEND_PAY, SEND_CSUM, WAIT_ACK, RECV_FRAME
  } state_t;
  state_t               state_q, state_d;
  logic [7:0]           tag_q, tag_d, len_q, len_d, idx_q, idx_d;
  logic [7:0]           csum_q, csum_d, byte_q, byte_d, retry_q, retry_d;
  logic [8*MAX_LEN-1:0] pay_q, pay_d;
  logic [23:0]          frame_q, frame_d;
  logic [1:0]           fb_q, fb_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 gap_q, gap_d, ready_q, ready_d, rsp_valid_q, rsp_valid_d;
  logic [2:0]           status_q, status_d, fin_st;
  logic [31:0]          fnum_q, fnum_d;
  logic [7:0]           pay_byte, pay_wire, tx_cur;
  logic                 tx_go, timeout, fin;
  assign pay_byte = pay_q[8*int'(idx_q) +: 8];
  // payload bytes travel MSB-first relative to the receiver's buffer bit order
  always_comb
    for (int i = 0; i < 8; i++) pay_wire[i] = pay_byte[7-i];
  assign tx_cur = state_q == SEND_TAG ? tag_q :
                  state_q == SEND_LEN ? len_q :
                  state_q == SEND_PAY ? pay_wire : csum_q;
  // gap_q blocks the cycle right after a strobe so the core has time to raise busy;
  // rst_n gating keeps a frame from emitting a byte in the very cycle it is aborted
  assign tx_go = rst_n && !uart_tx_busy && !gap_q &&
                 (state_q inside {SEND_TAG, SEND_LEN, SEND_PAY, SEND_CSUM});
  assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    len_d       = len_q;
    pay_d       = pay_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    byte_d      = byte_q;
    retry_d     = retry_q;
    frame_d     = frame_q;
    fb_d        = fb_q;
    cnt_d       = cnt_q;
    gap_d       = tx_go;
    rsp_valid_d = 1'b0;
    status_d    = status_q;
    fnum_d      = fnum_q;
    fin         = 1'b0;
    fin_st      = 3'd0;
    if (tx_go) begin
      byte_d = tx_cur;
      csum_d = csum_q ^ tx_cur;
    end
    unique case (state_q)
      IDLE: if (cmd_valid && ready_q) begin
        tag_d   = cmd_tag;
        len_d   = cmd_len;
        pay_d   = cmd_payload;
        idx_d   = 8'd0;
        csum_d  = 8'd0;
        retry_d = 8'd0;
        if (cmd_len > 8'(MAX_LEN)) begin
          fin    = 1'b1;
          fin_st = 3'd4;
        end else state_d = SEND_TAG;
      end
      SEND_TAG: if (tx_go) state_d = SEND_LEN;
      SEND_LEN: if (tx_go) state_d = len_q == 8'd0 ? SEND_CSUM : SEND_PAY;
      SEND_PAY: if (tx_go) begin
        idx_d = idx_q + 8'd1;
        if (idx_q == len_q - 8'd1) state_d = SEND_CSUM;
      end
      SEND_CSUM: if (tx_go) begin
        state_d = WAIT_ACK;
        cnt_d   = '0;
      end
      WAIT_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          fin    = 1'b1;
          fin_st = 3'd3;
        end else if (uart_rx_new_data) begin
          cnt_d = '0;
          if (uart_rx_byte == 8'h00 && tag_q == 8'h05) begin
            state_d = RECV_FRAME;
            fb_d    = 2'd0;
          end else if (uart_rx_byte == 8'hFF && retry_q < 8'(MAX_RETRIES)) begin
            retry_d = retry_q + 8'd1;
            idx_d   = 8'd0;
            csum_d  = 8'd0;
            state_d = SEND_TAG;
          end else begin
            fin    = 1'b1;
            fin_st = uart_rx_byte == 8'h00 ? 3'd0 :
                     uart_rx_byte == 8'hFF ? 3'd1 :
                     uart_rx_byte == 8'h01 ? 3'd2 : 3'd5;
          end
        end
      end
      RECV_FRAME: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          fin    = 1'b1;
          fin_st = 3'd3;
        end else if (uart_rx_new_data) begin
          cnt_d   = '0;
          frame_d = {uart_rx_byte, frame_q[23:8]};
          fb_d    = fb_q + 2'd1;
          if (fb_q == 2'd3) begin
            fin    = 1'b1;
            fin_st = 3'd0;
            fnum_d = {uart_rx_byte, frame_q};
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b1;
      status_d    = fin_st;
    end
    ready_d = state_d == IDLE && !rsp_valid_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      len_q       <= '0;
      pay_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      byte_q      <= '0;
      retry_q     <= '0;
      frame_q     <= '0;
      fb_q        <= '0;
      cnt_q       <= '0;
      gap_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      status_q    <= '0;
      fnum_q      <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      len_q       <= len_d;
      pay_q       <= pay_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      byte_q      <= byte_d;
      retry_q     <= retry_d;
      frame_q     <= frame_d;
      fb_q        <= fb_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      status_q    <= status_d;
      fnum_q      <= fnum_d;
    end
  end
  assign cmd_ready     = ready_q;
  assign uart_tx_start = tx_go;
  assign uart_tx_byte  = byte_d;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_status    = status_q;
  assign rsp_frame_num = fnum_q;
endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: self-checking bench for uart_cmd_master with a behavioural link model
`timescale 1ns/1ps
module tb_uart_cmd_master;
  localparam int ML = 38;
  localparam int TO = 100;
  localparam int MR = 3;
  typedef logic [7:0] bytes_t [$];
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          rst_n = 1'b0, cmd_valid = 1'b0, cmd_ready;
  logic [7:0]    cmd_tag = '0, cmd_len = '0;
  logic [8*ML-1:0] cmd_payload = '0;
  logic          uart_tx_busy, uart_tx_start;
  logic [7:0]    uart_tx_byte;
  logic          uart_rx_new_data = 1'b0;
  logic [7:0]    uart_rx_byte = '0;
  logic          rsp_valid;
  logic [2:0]    rsp_status;
  logic [31:0]   rsp_frame_num;
  uart_cmd_master #(.MAX_LEN(ML), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tag(cmd_tag), .cmd_len(cmd_len), .cmd_payload(cmd_payload),
    .uart_tx_busy(uart_tx_busy), .uart_tx_start(uart_tx_start), .uart_tx_byte(uart_tx_byte),
    .uart_rx_new_data(uart_rx_new_data), .uart_rx_byte(uart_rx_byte),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_frame_num(rsp_frame_num));
  int cyc = 0, busy_cnt = 0, busy_len = 1, viol = 0, last_tx = -10, last_rx = 0;
  int n_chk = 0, n_fail = 0, tx_base = 0, rsp_base = 0;
  logic hold_busy = 1'b0, strobed = 1'b0;
  logic [31:0] exp_fn = '0;
  logic [7:0] txq [$];
  int txc [$], rsp_c [$];
  logic [2:0] rsp_s [$];
  logic [31:0] rsp_f [$];
  assign uart_tx_busy = hold_busy || busy_cnt > 0;
  // TX core model: busy for busy_len cycles after every accepted strobe
  always @(posedge clk) begin
    cyc++;
    if (strobed) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
  end
  always @(negedge clk) begin
    strobed = uart_tx_start;
    if (uart_tx_start) begin
      if (uart_tx_busy || cyc - last_tx < 2) viol++;
      last_tx = cyc;
      txq.push_back(uart_tx_byte);
      txc.push_back(cyc);
    end
    if (rsp_valid) begin
      rsp_c.push_back(cyc);
      rsp_s.push_back(rsp_status);
      rsp_f.push_back(rsp_frame_num);
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end
  task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int n_tx();
    return txq.size() - tx_base;
  endfunction
  function automatic int n_rsp();
    return rsp_c.size() - rsp_base;
  endfunction
  task automatic begin_test();
    tx_base = txq.size();
    rsp_base = rsp_c.size();
  endtask
  // wire image of one frame, straight from the protocol rules
  function automatic bytes_t mk_frame(input logic [7:0] tag, input logic [7:0] len, input logic [8*ML-1:0] p);
    bytes_t f;
    logic [7:0] cs, w;
    f.push_back(tag);
    f.push_back(len);
    cs = tag ^ len;
    for (int k = 0; k < int'(len); k++) begin
      for (int i = 0; i < 8; i++) w[7-i] = p[8*k+i];
      f.push_back(w);
      cs ^= w;
    end
    f.push_back(cs);
    return f;
  endfunction
  task automatic do_cmd(input logic [7:0] tag, input logic [7:0] len, input logic [8*ML-1:0] p,
                        input logic hold, output int acc);
    int w = 0;
    while (!(cmd_ready && !uart_tx_busy) && w < 500) begin
      tick();
      w++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_tag = tag;
    cmd_len = len;
    cmd_payload = p;
    hold_busy = hold;
    acc = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic wait_tx(input int n);
    int w = 0;
    while (n_tx() < n && w < 3000) begin
      tick();
      w++;
    end
    check("wait_tx_bytes", 32'(n_tx() >= n), 1);
  endtask
  task automatic reply(input logic [7:0] b);
    uart_rx_new_data = 1'b1;
    uart_rx_byte = b;
    last_rx = cyc;
    tick();
    uart_rx_new_data = 1'b0;
  endtask
  task automatic run_cmd(input string nm, input logic [7:0] tag, input logic [7:0] len,
                         input logic [8*ML-1:0] p, input bytes_t rep, input int hold);
    bytes_t f;
    int acc, frames, retries, nb, rel, clr, w, mism, lim;
    logic done, in_frame;
    logic [2:0] st;
    logic [31:0] fn;
    f = mk_frame(tag, len, p);
    frames = 1; retries = 0; nb = 0; done = 0; in_frame = 0; st = 3'd3; fn = 0; rel = 0;
    begin_test();
    do_cmd(tag, len, p, hold > 0, acc);
    if (hold > 0) begin
      repeat (hold) tick();
      check({nm, "_held_no_tx"}, n_tx(), 0);
      rel = cyc;
      hold_busy = 1'b0;
    end
    wait_tx(f.size());
    if (hold > 0) check({nm, "_first_after_release"}, 32'(txc[tx_base] >= rel), 1);
    else check({nm, "_first_strobe"}, txc[tx_base], acc + 1);
    clr = txc[txc.size()-1] + 1;
    foreach (rep[i]) begin
      if (done) break;
      reply(rep[i]);
      clr = last_rx + 1;
      if (in_frame) begin
        fn = fn | (32'(rep[i]) << (8*nb));
        nb++;
        if (nb == 4) begin
          done = 1;
          st = 3'd0;
        end
      end else if (rep[i] == 8'hFF && retries < MR) begin
        retries++;
        frames++;
        wait_tx(frames * f.size());
        clr = txc[txc.size()-1] + 1;
      end else begin
        in_frame = rep[i] == 8'h00 && tag == 8'h05;
        done = !in_frame;
        st = rep[i] == 8'h00 ? 3'd0 : rep[i] == 8'hFF ? 3'd1 : rep[i] == 8'h01 ? 3'd2 : 3'd5;
      end
    end
    if (!done) st = 3'd3;
    if (done && st == 3'd0 && tag == 8'h05) exp_fn = fn;
    w = 0;
    while (n_rsp() < 1 && w < TO + 300) begin
      tick();
      w++;
    end
    check({nm, "_rsp_seen"}, 32'(n_rsp() >= 1), 1);
    if (n_rsp() >= 1) begin
      check({nm, "_status"}, 32'(rsp_s[rsp_base]), 32'(st));
      check({nm, "_rsp_cycle"}, rsp_c[rsp_base], done ? last_rx + 1 : clr + TO);
      check({nm, "_frame_num"}, rsp_f[rsp_base], exp_fn);
      check({nm, "_ready_after"}, cmd_ready, 1'b1);
    end
    check({nm, "_tx_count"}, n_tx(), frames * f.size());
    mism = 0;
    lim = n_tx() < frames * f.size() ? n_tx() : frames * f.size();
    for (int j = 0; j < lim; j++) if (txq[tx_base+j] !== f[j % f.size()]) mism++;
    check({nm, "_tx_bytes_mismatches"}, mism, 0);
  endtask
  initial begin
    logic [8*ML-1:0] p;
    bytes_t rp;
    int acc, r, t;
    logic [7:0] tg, ln, term;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_tx_start", uart_tx_start, 1'b0);
    check("rst_tx_byte", uart_tx_byte, 8'h00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_status", rsp_status, 3'd0);
    check("rst_frame_num", rsp_frame_num, 32'h0);
    rst_n = 1'b1;
    check("release_ready_low", cmd_ready, 1'b0);
    tick();
    check("release_ready_high", cmd_ready, 1'b1);
    p = '0;
    p[7:0] = 8'h02;
    busy_len = 2;
    rp = '{8'h00};
    run_cmd("basic", 8'h08, 8'd1, p, rp, 0);
    check("basic_wire_tag", txq[tx_base], 8'h08);
    check("basic_wire_payload", txq[tx_base+2], 8'h40);
    check("basic_wire_csum", txq[tx_base+3], 8'h49);
    rp = '{8'hFF, 8'hFF, 8'h00};
    run_cmd("retry2", 8'h08, 8'd1, p, rp, 0);
    rp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_cmd("nack", 8'h08, 8'd1, p, rp, 0);
    p = '0;
    rp = '{8'h00, 8'h2A, 8'h01, 8'h00, 8'h00};
    run_cmd("frame", 8'h05, 8'd0, p, rp, 0);
    check("frame_value", rsp_frame_num, 32'h0000012A);
    check("frame_wire_csum", txq[tx_base+2], 8'h05);
    for (int k = 0; k < ML; k++) p[8*k +: 8] = 8'($urandom);
    rp.delete();
    run_cmd("timeout", 8'h11, 8'd3, p, rp, 0);
    check("timeout_holds_fnum", rsp_frame_num, 32'h0000012A);
    rp = '{8'h37};
    run_cmd("proto", 8'h21, 8'd2, p, rp, 0);
    rp = '{8'h01};
    run_cmd("unknown", 8'h7E, 8'd4, p, rp, 0);
    rp = '{8'h00, 8'hAA};
    run_cmd("frame_timeout", 8'h05, 8'd1, p, rp, 0);
    rp = '{8'h00};
    run_cmd("maxlen", 8'h30, 8'(ML), p, rp, 0);
    begin_test();
    do_cmd(8'h09, 8'(ML + 1), p, 1'b0, acc);
    check("badlen_rsp_valid", rsp_valid, 1'b1);
    check("badlen_status", rsp_status, 3'd4);
    check("badlen_ready_low", cmd_ready, 1'b0);
    repeat (10) tick();
    check("badlen_no_tx", n_tx(), 0);
    check("badlen_one_rsp", n_rsp(), 1);
    check("badlen_ready_after", cmd_ready, 1'b1);
    busy_len = 3;
    rp = '{8'h00};
    run_cmd("hold50", 8'h0A, 8'd2, p, rp, 50);
    begin_test();
    do_cmd(8'h0C, 8'd12, p, 1'b0, acc);
    wait_tx(5);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("rstmid_no_more_tx", n_tx(), 5);
    check("rstmid_no_rsp", n_rsp(), 0);
    check("rstmid_ready", cmd_ready, 1'b1);
    check("rstmid_fnum_cleared", rsp_frame_num, 32'h0);
    exp_fn = '0;
    p = '0;
    p[7:0] = 8'h02;
    rp = '{8'h00};
    run_cmd("after_rst", 8'h08, 8'd1, p, rp, 0);
    for (int n = 0; n < 12; n++) begin
      tg = 8'($urandom);
      if ($urandom_range(0, 2) == 0) tg = 8'h05;
      ln = 8'($urandom_range(0, ML));
      for (int k = 0; k < ML; k++) p[8*k +: 8] = 8'($urandom);
      busy_len = $urandom_range(1, 5);
      r = $urandom_range(0, 4);
      rp.delete();
      repeat (r) rp.push_back(8'hFF);
      if (r < 4) begin
        t = $urandom_range(0, 3);
        term = t == 1 ? 8'h01 : t == 2 ? 8'h37 : 8'h00;
        rp.push_back(term);
        if (term == 8'h00 && tg == 8'h05) repeat (4) rp.push_back(8'($urandom));
      end
      run_cmd("rand", tg, ln, p, rp, 0);
    end
    check("tx_handshake_violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
